dac_spi_seq: RTL and testbench

DAC_SPI_SEQ -- requirements
Module: dac_spi_seq

---
 rtl/dac_spi_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_dac_spi_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_seq.sv
// AD9148 SPI init sequencer: pulses the DAC reset, replays a register table,
// then serves single host transactions with optional 8-bit read-back.
module dac_spi_seq #(
    parameter int CLKDIV     = 4,
    parameter int RST_CYCLES = 256,
    parameter int TBL_LEN    = 32,
    localparam int AW        = (TBL_LEN > 1) ? $clog2(TBL_LEN) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [15:0]   host_word,
    output logic [7:0]    rdata,
    output logic          rvalid,
    output logic          dac_spi_rstn,
    output logic          dac_spi_cs_n,
    output logic          dac_spi_sclk,
    output logic          dac_spi_mosi,
    input  logic          dac_spi_miso
);

    localparam int CMAX = (RST_CYCLES > 2 * CLKDIV) ? RST_CYCLES : 2 * CLKDIV;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLKDIV - 1);
    localparam logic [AW:0]   TBL_END   = (AW + 1)'(TBL_LEN);
    localparam logic [5:0]    PH_LAST   = 6'd32;

    typedef enum logic [2:0] {IDLE, RST, RWAIT, FETCH, SHIFT, GAP, HOST} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    ph_q, ph_d;
    logic [AW:0]   idx_q, idx_d;
    logic [15:0]   sr_q, sr_d;
    logic [7:0]    rsh_q, rsh_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          is_rd_q, is_rd_d;
    logic          is_tbl_q, is_tbl_d;
    logic          rvalid_q, rvalid_d;
    logic          done_q, done_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, hready_q, cs_n_q, spi_rstn_q;
    logic [AW-1:0] addr_q;

    // A frame is phase 0 (cs_n setup, sclk low) followed by 32 sclk half-phases;
    // odd phases are high, and the final low phase doubles as the cs_n hold.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        idx_d    = idx_q;
        sr_d     = sr_q;
        rsh_d    = rsh_q;
        rdata_d  = rdata_q;
        is_rd_d  = is_rd_q;
        is_tbl_d = is_tbl_q;
        rvalid_d = 1'b0;
        done_d   = done_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d  = RST;
                    done_d   = 1'b0;
                    is_tbl_d = 1'b1;
                end else if (host_valid && hready_q) begin
                    state_d  = HOST;
                    sr_d     = host_word;
                    is_tbl_d = 1'b0;
                end
            end
            RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = RWAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RWAIT: begin
                idx_d = '0;
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FETCH: begin
                // Cycle 0 presents the address, cycle 1 sees the table word.
                if (cnt_q == '0) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    ph_d    = '0;
                    sr_d    = tbl_data;
                    is_rd_d = tbl_data[15];
                    mosi_d  = tbl_data[15];
                    state_d = SHIFT;
                end
            end
            HOST: begin
                cnt_d   = '0;
                ph_d    = '0;
                is_rd_d = sr_q[15];
                mosi_d  = sr_q[15];
                state_d = SHIFT;
            end
            SHIFT: begin
                // mosi moves one cycle into a low phase, well clear of both sclk edges.
                if (!ph_q[0] && (ph_q != '0) && (cnt_q == '0)) begin
                    if (ph_q == PH_LAST) begin
                        mosi_d = 1'b0;
                    end else begin
                        sr_d   = {sr_q[14:0], 1'b0};
                        mosi_d = sr_q[14];
                    end
                end
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (ph_q == PH_LAST) begin
                        state_d = GAP;
                        if (is_rd_q) begin
                            rdata_d  = rsh_q;
                            rvalid_d = 1'b1;
                        end
                    end else begin
                        ph_d   = ph_q + 6'd1;
                        sclk_d = ~ph_q[0];
                        if (!ph_q[0]) begin
                            rsh_d = {rsh_q[6:0], dac_spi_miso};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (is_tbl_q) begin
                        idx_d = idx_q + 1'b1;
                        if ((idx_q + 1'b1) == TBL_END) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ph_q       <= '0;
            idx_q      <= '0;
            sr_q       <= '0;
            rsh_q      <= '0;
            rdata_q    <= '0;
            is_rd_q    <= 1'b0;
            is_tbl_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            hready_q   <= 1'b0;
            cs_n_q     <= 1'b1;
            spi_rstn_q <= 1'b1;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            rsh_q      <= rsh_d;
            rdata_q    <= rdata_d;
            is_rd_q    <= is_rd_d;
            is_tbl_q   <= is_tbl_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= (state_d != IDLE);
            hready_q   <= (state_d == IDLE);
            cs_n_q     <= (state_d != SHIFT);
            spi_rstn_q <= (state_d != RST);
            addr_q     <= idx_d[AW-1:0];
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign tbl_addr     = addr_q;
    assign host_ready   = hready_q;
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign dac_spi_rstn = spi_rstn_q;
    assign dac_spi_cs_n = cs_n_q;
    assign dac_spi_sclk = sclk_q;
    assign dac_spi_mosi = mosi_q;

endmodule

// File: tb/tb_dac_spi_seq.sv
// Bench for dac_spi_seq: two instances (CLKDIV 2 and 3) observed by a pin-level
// SPI frame decoder that checks timing rules and decoded words every cycle.
module tb_dac_spi_seq;

    localparam int NI   = 2;
    localparam int CD0  = 2;
    localparam int CD1  = 3;
    localparam int RSTC = 4;
    localparam int TLEN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [NI-1:0]   start, host_valid, miso;
    logic [15:0]     host_word [NI];
    logic [15:0]     tbl_data  [NI];
    logic [NI-1:0]   busy, done, host_ready, rvalid;
    logic [NI-1:0]   spi_rstn, cs_n, sclk, mosi;
    logic [7:0]      rdata     [NI];
    logic [0:0]      tbl_addr  [NI];

    dac_spi_seq #(.CLKDIV(CD0), .RST_CYCLES(RSTC), .TBL_LEN(TLEN)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .tbl_addr(tbl_addr[0]), .tbl_data(tbl_data[0]),
        .host_valid(host_valid[0]), .host_ready(host_ready[0]), .host_word(host_word[0]),
        .rdata(rdata[0]), .rvalid(rvalid[0]),
        .dac_spi_rstn(spi_rstn[0]), .dac_spi_cs_n(cs_n[0]), .dac_spi_sclk(sclk[0]),
        .dac_spi_mosi(mosi[0]), .dac_spi_miso(miso[0])
    );

    dac_spi_seq #(.CLKDIV(CD1), .RST_CYCLES(RSTC), .TBL_LEN(TLEN)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .tbl_addr(tbl_addr[1]), .tbl_data(tbl_data[1]),
        .host_valid(host_valid[1]), .host_ready(host_ready[1]), .host_word(host_word[1]),
        .rdata(rdata[1]), .rvalid(rvalid[1]),
        .dac_spi_rstn(spi_rstn[1]), .dac_spi_cs_n(cs_n[1]), .dac_spi_sclk(sclk[1]),
        .dac_spi_mosi(mosi[1]), .dac_spi_miso(miso[1])
    );

    function automatic logic [15:0] rom_word(input logic [0:0] a);
        return a ? 16'h0300 : 16'h0020;
    endfunction

    always @(posedge clk) begin
        tbl_data[0] <= rom_word(tbl_addr[0]);
        tbl_data[1] <= rom_word(tbl_addr[1]);
    end

    int checks = 0;
    int errors = 0;

    // Expected SPI frames per instance, in order.
    logic [15:0] exp_mem [NI][32];
    int          exp_wr [NI] = '{default: 0};
    int          exp_rd [NI] = '{default: 0};

    // Decoder state.
    bit          p_cs [NI], p_sclk [NI], p_mosi [NI], p_srst [NI], rel_watch [NI];
    int          run [NI], rises [NI], hi_run [NI], low_rst [NI], rel_cnt [NI];
    int          edges [NI] = '{default: 0};
    int          rv_cnt [NI] = '{default: 0};
    int          frames [NI] = '{default: 0};
    logic [15:0] word [NI];
    logic [7:0]  rd_sh [NI], m_rdata [NI];
    logic [15:0] miso_word [NI];

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [15:0] w);
        exp_mem[i][exp_wr[i] % 32] = w;
        exp_wr[i]++;
    endtask

    task automatic chk_reset(input int i);
        check($sformatf("rst_cs_n[%0d]", i), cs_n[i], 1);
        check($sformatf("rst_sclk[%0d]", i), sclk[i], 0);
        check($sformatf("rst_mosi[%0d]", i), mosi[i], 0);
        check($sformatf("rst_dacrstn[%0d]", i), spi_rstn[i], 1);
        check($sformatf("rst_busy[%0d]", i), busy[i], 0);
        check($sformatf("rst_done[%0d]", i), done[i], 0);
        check($sformatf("rst_hready[%0d]", i), host_ready[i], 0);
        check($sformatf("rst_rvalid[%0d]", i), rvalid[i], 0);
        check($sformatf("rst_rdata[%0d]", i), rdata[i], 0);
        check($sformatf("rst_addr[%0d]", i), tbl_addr[i], 0);
    endtask

    task automatic mon(input int i);
        int cd;
        bit exp_rv;
        cd = (i == 0) ? CD0 : CD1;
        if (!rstn) begin
            chk_reset(i);
            p_cs[i] = 1; p_sclk[i] = 0; p_mosi[i] = 0; p_srst[i] = 1;
            run[i] = 0; rises[i] = 0; hi_run[i] = 1000; low_rst[i] = 0;
            rel_watch[i] = 0; rel_cnt[i] = 0; m_rdata[i] = 0;
            exp_rd[i] = exp_wr[i];
            miso[i] = 1'b0;
            return;
        end
        exp_rv = 0;
        if (sclk[i] != p_sclk[i]) edges[i]++;
        if (rvalid[i]) rv_cnt[i]++;
        if (cs_n[i]) begin
            check($sformatf("idle_sclk[%0d]", i), sclk[i], 0);
            check($sformatf("idle_mosi[%0d]", i), mosi[i], 0);
        end
        if (mosi[i] != p_mosi[i])
            check($sformatf("mosi_while_sclk_low[%0d]", i), p_sclk[i] | sclk[i], 0);
        if (busy[i]) check($sformatf("hready_when_busy[%0d]", i), host_ready[i], 0);
        if (!cs_n[i] || !spi_rstn[i]) check($sformatf("busy_active[%0d]", i), busy[i], 1);

        if (!cs_n[i] && p_cs[i]) begin
            check($sformatf("cs_gap[%0d]", i), hi_run[i] >= 2 * cd, 1);
            if (rel_watch[i]) begin
                check($sformatf("rwait_fetch_len[%0d]", i), rel_cnt[i], RSTC + 2);
                rel_watch[i] = 0;
            end
            run[i] = 1; rises[i] = 0; word[i] = '0; rd_sh[i] = '0;
        end else if (!cs_n[i]) begin
            if (sclk[i] != p_sclk[i]) begin
                if (sclk[i] && rises[i] == 0)
                    check($sformatf("cs_setup[%0d]", i), run[i] >= cd, 1);
                else
                    check($sformatf("sclk_phase[%0d]", i), run[i], cd);
                run[i] = 1;
                if (sclk[i]) begin
                    rises[i]++;
                    word[i]  = {word[i][14:0], mosi[i]};
                    rd_sh[i] = {rd_sh[i][6:0], miso[i]};
                end
            end else begin
                run[i]++;
            end
        end else if (!p_cs[i]) begin
            check($sformatf("rises[%0d]", i), rises[i], 16);
            check($sformatf("cs_hold[%0d]", i), run[i], cd);
            if (exp_rd[i] == exp_wr[i]) begin
                check($sformatf("unexpected_frame[%0d]", i), word[i], 32'hFFFF_FFFF);
            end else begin
                check($sformatf("frame_word[%0d]", i), word[i], exp_mem[i][exp_rd[i] % 32]);
                exp_rd[i]++;
            end
            frames[i]++;
            if (word[i][15]) begin
                exp_rv = 1;
                m_rdata[i] = rd_sh[i];
            end
            hi_run[i] = 1;
        end else begin
            hi_run[i]++;
        end
        check($sformatf("rvalid[%0d]", i), rvalid[i], exp_rv);
        check($sformatf("rdata[%0d]", i), rdata[i], m_rdata[i]);

        if (!spi_rstn[i]) begin
            check($sformatf("cs_in_dac_reset[%0d]", i), cs_n[i], 1);
            low_rst[i]++;
        end else if (!p_srst[i]) begin
            check($sformatf("dac_rst_low_len[%0d]", i), low_rst[i], RSTC);
            low_rst[i] = 0; rel_watch[i] = 1; rel_cnt[i] = 1;
        end else if (rel_watch[i] && cs_n[i]) begin
            rel_cnt[i]++;
        end

        // Slave model: present the bit for the next sclk rise.
        miso[i] = (!cs_n[i] && rises[i] < 16) ? miso_word[i][15 - rises[i]] : 1'b0;
        p_cs[i] = cs_n[i]; p_sclk[i] = sclk[i]; p_mosi[i] = mosi[i]; p_srst[i] = spi_rstn[i];
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) mon(i);
    endtask

    task automatic wait_idle(input int i, input int lim);
        int n = 0;
        while (busy[i] && n < lim) begin
            tick();
            n++;
        end
        check($sformatf("wait_idle[%0d]", i), busy[i], 0);
    endtask

    task automatic host_xfer(input int i, input logic [15:0] w, input int lim);
        int n = 0;
        host_word[i]  = w;
        host_valid[i] = 1'b1;
        while (!host_ready[i] && n < lim) begin
            tick();
            n++;
        end
        check($sformatf("host_ready_seen[%0d]", i), host_ready[i], 1);
        tick();
        host_valid[i] = 1'b0;
        $display("host[%0d] word 0x%04h accepted", i, w);
    endtask

    initial begin
        int f0, r0, e0, n;
        rstn = 1'b1; start = '0; host_valid = '0; miso = '0;
        host_word[0] = '0; host_word[1] = '0;
        miso_word[0] = '0; miso_word[1] = '0;
        word[0] = '0; word[1] = '0;
        #2 rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        @(posedge clk); #1;
        check("hready_after_reset0", host_ready[0], 1);
        check("hready_after_reset1", host_ready[1], 1);
        repeat (20) tick();
        check("no_autostart_edges", edges[0] + edges[1], 0);
        check("no_autostart_busy", busy[0], 0);

        // Init run, with a stray start mid-run that must be ignored.
        push(0, 16'h0020); push(0, 16'h0300);
        f0 = frames[0];
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        repeat (20) tick();
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        wait_idle(0, 2000);
        check("init_done", done[0], 1);
        check("init_frames", frames[0] - f0, 2);
        check("init_last_word", word[0], 16'h0300);
        $display("init[0] frames %0d done %0b", frames[0] - f0, done[0]);

        // Host read.
        miso_word[0] = 16'h005C;
        push(0, 16'h8A00);
        r0 = rv_cnt[0];
        host_xfer(0, 16'h8A00, 50);
        wait_idle(0, 500);
        check("read_rdata", rdata[0], 8'h5C);
        check("read_rvalid_pulses", rv_cnt[0] - r0, 1);
        $display("read[0] rdata 0x%02h", rdata[0]);

        // Host write.
        push(0, 16'h0155);
        r0 = rv_cnt[0];
        host_xfer(0, 16'h0155, 50);
        wait_idle(0, 500);
        check("write_word", word[0], 16'h0155);
        check("write_rdata_kept", rdata[0], 8'h5C);
        check("write_no_rvalid", rv_cnt[0] - r0, 0);
        $display("write[0] word 0x%04h", word[0]);

        // Contention: start and host_valid together; host must wait for the init run.
        push(0, 16'h0020); push(0, 16'h0300); push(0, 16'h0A33);
        host_word[0] = 16'h0A33; host_valid[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n = 0;
        while (!host_ready[0] && n < 2000) begin
            tick();
            n++;
        end
        check("host_waits_for_done", done[0], 1);
        check("host_ready_after_init", host_ready[0], 1);
        tick();
        host_valid[0] = 1'b0;
        wait_idle(0, 500);
        check("contention_last_word", word[0], 16'h0A33);
        check("done_kept_by_host", done[0], 1);
        $display("contention[0] host word 0x%04h after init", word[0]);

        // Mid-frame reset.
        push(0, 16'h0020);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        check("done_cleared_by_start", done[0], 0);
        n = 0;
        while (!(rises[0] == 7 && !cs_n[0]) && n < 500) begin
            tick();
            n++;
        end
        check("reach_bit7", rises[0], 7);
        @(posedge clk); #2 rstn = 1'b0;
        #1 chk_reset(0);
        repeat (3) tick();
        rstn = 1'b1;
        e0 = edges[0];
        repeat (100) tick();
        check("no_sclk_after_reset", edges[0] - e0, 0);
        check("idle_after_reset", busy[0], 0);
        $display("midframe reset[0] edges after release %0d", edges[0] - e0);

        // CLKDIV = 3 instance: read then init run.
        miso_word[1] = 16'h00A5;
        push(1, 16'h8A00);
        e0 = edges[1];
        host_xfer(1, 16'h8A00, 50);
        wait_idle(1, 500);
        check("div3_rdata", rdata[1], 8'hA5);
        check("div3_edges", edges[1] - e0, 32);
        push(1, 16'h0020); push(1, 16'h0300);
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        wait_idle(1, 3000);
        check("div3_done", done[1], 1);
        $display("div3[1] rdata 0x%02h done %0b", rdata[1], done[1]);

        repeat (5) tick();
        check("frames_pending0", exp_wr[0] - exp_rd[0], 0);
        check("frames_pending1", exp_wr[1] - exp_rd[1], 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
